// File: rtl/mult_pkg.sv
// Shared constants and radix-4 Booth helpers for the signed 32x32 multiplier.
package mult_pkg;

  localparam int OP_W     = 32;
  localparam int PROD_W   = 64;
  localparam int NUM_PP   = 17;
  localparam int NUM_ROWS = NUM_PP + 2;
  localparam int NUM_LVL  = 6;

  // Folded sign-extension constant: -(2^32 + 2^34 + ... + 2^62) mod 2^64
  localparam logic [PROD_W-1:0] SIGN_FIX = 64'hAAAA_AAAB_0000_0000;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  function automatic booth_digit_t booth_encode(input logic [2:0] bits);
    booth_digit_t d;
    case (bits)
      3'b000, 3'b111: d = booth_digit_t'(3'b000);
      3'b001, 3'b010: d = booth_digit_t'(3'b010);
      3'b011:         d = booth_digit_t'(3'b001);
      3'b100:         d = booth_digit_t'(3'b101);
      3'b101, 3'b110: d = booth_digit_t'(3'b110);
      default:        d = booth_digit_t'(3'b000);
    endcase
    return d;
  endfunction

  function automatic int csa_rows(input int lvl);
    int n;
    n = NUM_ROWS;
    for (int l = 0; l < lvl; l++) begin
      n = (n / 3) * 2 + (n % 3);
    end
    return n;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One radix-4 Booth digit encoder and its 33-bit partial-product row.
module booth_pp_gen
  import mult_pkg::*;
(
  input  logic [2:0]      triplet,
  input  logic [OP_W-1:0] multiplicand,
  output logic [OP_W:0]   row,
  output logic            neg
);

  booth_digit_t    digit_s;
  logic [OP_W:0]   mag_s;
  logic [OP_W:0]   sel_s;

  // Select 0/B/2B at 33 bits so -2*(-2^31) cannot overflow; the row's sign is
  // flipped to feed the constant-prefix sign-extension scheme.
  always_comb begin
    digit_s = booth_encode(triplet);
    if (digit_s.one) begin
      mag_s = {multiplicand[OP_W-1], multiplicand};
    end else if (digit_s.two) begin
      mag_s = {multiplicand, 1'b0};
    end else begin
      mag_s = '0;
    end
    if (digit_s.neg) begin
      sel_s = ~mag_s;
    end else begin
      sel_s = mag_s;
    end
    row = {~sel_s[OP_W], sel_s[OP_W-1:0]};
    neg = digit_s.neg;
  end

endmodule

// File: rtl/top_mult32.sv
// Two-stage signed 32x32->64 multiplier: operand registers, Booth rows,
// carry-save tree and final adder, then the product register.
module top_mult32
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   multiplier,
  input  logic [OP_W-1:0]   multiplicand,
  output logic [PROD_W-1:0] product
);

  logic [OP_W-1:0]   a_r;
  logic [OP_W-1:0]   b_r;
  logic [OP_W+2:0]   a_ext_s;
  logic [OP_W:0]     row_s [NUM_PP];
  logic [NUM_PP-1:0] neg_s;
  logic [PROD_W-1:0] corr_s;
  logic [PROD_W-1:0] sum_s;
  logic [PROD_W-1:0] tree_s [NUM_LVL+1][NUM_ROWS];

  assign a_ext_s = {a_r[OP_W-1], a_r[OP_W-1], a_r, 1'b0};

  for (genvar j = 0; j < NUM_PP; j++) begin : g_pp
    booth_pp_gen u_pp (
      .triplet      (a_ext_s[2*j+2 -: 3]),
      .multiplicand (b_r),
      .row          (row_s[j]),
      .neg          (neg_s[j])
    );
    assign tree_s[0][j] = {{(PROD_W-OP_W-1){1'b0}}, row_s[j]} << (2*j);
  end

  // Gather the +1 corrections of the negated rows into one sparse row
  always_comb begin
    corr_s = '0;
    for (int j = 0; j < NUM_PP; j++) begin
      corr_s[2*j] = neg_s[j];
    end
  end

  assign tree_s[0][NUM_PP]   = corr_s;
  assign tree_s[0][NUM_PP+1] = SIGN_FIX;

  for (genvar l = 0; l < NUM_LVL; l++) begin : g_lvl
    localparam int N_IN  = csa_rows(l);
    localparam int N_GRP = N_IN / 3;
    localparam int N_REM = N_IN % 3;
    localparam int N_OUT = 2 * N_GRP + N_REM;
    for (genvar g = 0; g < N_GRP; g++) begin : g_csa
      assign tree_s[l+1][2*g]   = tree_s[l][3*g] ^ tree_s[l][3*g+1] ^ tree_s[l][3*g+2];
      assign tree_s[l+1][2*g+1] = ((tree_s[l][3*g]   & tree_s[l][3*g+1]) |
                                   (tree_s[l][3*g]   & tree_s[l][3*g+2]) |
                                   (tree_s[l][3*g+1] & tree_s[l][3*g+2])) << 1;
    end
    for (genvar r = 0; r < N_REM; r++) begin : g_pass
      assign tree_s[l+1][2*N_GRP+r] = tree_s[l][3*N_GRP+r];
    end
    for (genvar z = N_OUT; z < NUM_ROWS; z++) begin : g_zero
      assign tree_s[l+1][z] = '0;
    end
  end

  assign sum_s = tree_s[NUM_LVL][0] + tree_s[NUM_LVL][1];

  // Operand and product registers; rst_n is active-high and asynchronous
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      product <= '0;
    end else begin
      a_r     <= multiplier;
      b_r     <= multiplicand;
      product <= sum_s;
    end
  end

endmodule

// File: tb/tb_top_mult32.sv
// Directed and random checks for top_mult32: latency 2, exact signed product,
// asynchronous active-high reset.
module tb_top_mult32;

  logic        clk;
  logic        rst_n;
  logic [31:0] multiplier;
  logic [31:0] multiplicand;
  logic [63:0] product;

  int n_vec;
  int n_miss;

  logic [63:0] exp1, exp2;
  logic        vld1, vld2;
  string       tag1, tag2;

  top_mult32 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: product=%h expected=%h", tag, got, want);
    end
  endtask

  // Called on a falling edge: check the result due now, then present new operands
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] e);
    if (vld2) check_val(tag2, product, exp2);
    exp2 = exp1; vld2 = vld1; tag2 = tag1;
    exp1 = e;    vld1 = 1'b1; tag1 = tag;
    multiplier   = a;
    multiplicand = b;
    @(negedge clk);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    n_vec = 0; n_miss = 0;
    vld1 = 1'b0; vld2 = 1'b0; exp1 = '0; exp2 = '0; tag1 = ""; tag2 = "";
    rst_n = 1'b1;
    multiplier   = 32'h1234_5678;
    multiplicand = 32'h0BAD_F00D;
    repeat (3) @(negedge clk);
    check_val("in_reset", product, 64'h0);
    multiplier   = 32'h0;
    multiplicand = 32'h0;
    @(negedge clk);
    check_val("in_reset_zero_ops", product, 64'h0);

    // Release: both stages hold zero, so the first two outputs read 0
    rst_n = 1'b0;
    exp1 = 64'h0; exp2 = 64'h0; vld1 = 1'b1; vld2 = 1'b1; tag1 = "post_rst0"; tag2 = "post_rst1";
    apply("zero_a", 32'h0, 32'h0, 64'h0);
    apply("zero_b", 32'h0, 32'h0, 64'h0);
    apply("zero_c", 32'h0, 32'h0, 64'h0);
    apply("3x5", 32'd3, 32'd5, 64'd15);
    apply("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    apply("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    apply("max_x_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    apply("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    apply("m7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
    apply("min_x_1", 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
    apply("m1_x_min", 32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000);
    apply("hex_x16", 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780);
    apply("m2_x_m3", 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6);

    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      apply("random", ra, rb, ref_mul(ra, rb));
    end

    // Asynchronous reset between edges while results are in flight
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check_val("async_rst_immediate", product, 64'h0);
    multiplier   = 32'h5555_5555;
    multiplicand = 32'h7777_7777;
    @(negedge clk);
    check_val("async_rst_hold", product, 64'h0);
    @(negedge clk);
    rst_n = 1'b0;
    exp1 = 64'h0; exp2 = 64'h0; vld1 = 1'b1; vld2 = 1'b1; tag1 = "rst2_a"; tag2 = "rst2_b";
    apply("after_rst_1", 32'd100, 32'hFFFF_FF9C, 64'hFFFF_FFFF_FFFF_D8F0);
    apply("after_rst_2", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      apply("random2", ra, rb, ref_mul(ra, rb));
    end
    apply("drain_1", 32'h0, 32'h0, 64'h0);
    apply("drain_2", 32'h0, 32'h0, 64'h0);
    apply("drain_3", 32'h0, 32'h0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
